sr_chain_bist: RTL and testbench



---
 rtl/sr_chain_bist.sv | 114 +++++++++++
 tb/tb_sr_chain_bist.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sr_chain_bist.sv
// PRBS7 built-in self-test for the delay-line shift register: fills the chain,
// then compares its serial output against a re-seeded copy of the same stream.
module sr_chain_bist #(
   parameter int unsigned LATENCY = 128,
   parameter int unsigned NBITS   = 256,
   parameter logic [6:0]  SEED    = 7'h7F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sr_sense,
   output logic        sr_drive,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_count,
   output logic [15:0] first_err
);

   localparam int unsigned PRBS_W = 7;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned ERR_W  = 8;

   localparam logic [PRBS_W-1:0] SEED_EFF   = (SEED == 7'd0) ? 7'h7F : SEED;
   localparam logic [CNT_W-1:0]  FILL_LAST  = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0]  CHECK_LAST = CNT_W'(NBITS - 1);
   localparam logic [CNT_W-1:0]  NO_ERR     = 16'hFFFF;
   localparam logic [ERR_W-1:0]  ERR_MAX    = 8'hFF;

   typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

   // x^7 + x^6 + 1, output taken from s[6]
   function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   state_t              state;
   logic [PRBS_W-1:0]   gen;
   logic [PRBS_W-1:0]   chk;
   logic [CNT_W-1:0]    cnt;

   logic                mismatch_c;
   logic [ERR_W-1:0]    err_next_c;

   always_comb begin
      mismatch_c = sr_sense ^ chk[6];
      err_next_c = err_count;
      if (mismatch_c && (err_count != ERR_MAX))
         err_next_c = err_count + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gen       <= SEED_EFF;
         chk       <= SEED_EFF;
         cnt       <= '0;
         sr_drive  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         first_err <= NO_ERR;
      end else begin
         case (state)
            IDLE, DONE: begin
               // launch: first PRBS bit goes out on the start edge itself
               if (start) begin
                  state     <= FILL;
                  sr_drive  <= SEED_EFF[6];
                  gen       <= prbs_next(SEED_EFF);
                  cnt       <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  first_err <= NO_ERR;
               end
            end
            FILL: begin
               sr_drive <= gen[6];
               gen      <= prbs_next(gen);
               if (cnt == FILL_LAST) begin
                  state <= CHECK;
                  chk   <= SEED_EFF;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            CHECK: begin
               chk       <= prbs_next(chk);
               err_count <= err_next_c;
               if (mismatch_c && (first_err == NO_ERR))
                  first_err <= cnt;
               if (cnt == CHECK_LAST) begin
                  state    <= DONE;
                  sr_drive <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= (err_next_c == '0);
                  cnt      <= '0;
               end else begin
                  sr_drive <= gen[6];
                  gen      <= prbs_next(gen);
                  cnt      <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_chain_bist.sv
// Directed bench for sr_chain_bist: flop-chain loopback with fault injection,
// mid-run reset, ignored/accepted start pulses and error-count saturation.
module tb_sr_chain_bist;

   localparam int unsigned L  = 128;
   localparam int unsigned N  = 256;
   localparam int unsigned N2 = 1000;
   localparam int unsigned D2 = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sr_sense;
   logic        sr_drive;
   logic        busy, done, pass;
   logic [7:0]  err_count;
   logic [15:0] first_err;

   logic        start2 = 1'b0;
   logic        sat_sense;
   logic        sat_drive;
   logic        sat_busy, sat_done, sat_pass;
   logic [7:0]  sat_err;
   logic [15:0] sat_first;

   // loopback modes: 0 = L flops, 1 = L+1 flops, 2 = stuck 0, 3 = stuck 1
   logic [1:0]    mode = 2'd0;
   logic          flip = 1'b0;
   logic [L:0]    pipe = '0;
   logic [D2-1:0] pipe2 = '0;

   int checks = 0;
   int errors = 0;
   int cyc;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pipe  <= {pipe[L-1:0], sr_drive};
      pipe2 <= {pipe2[D2-2:0], sat_drive};
   end

   always_comb begin
      case (mode)
         2'd0:    sr_sense = pipe[L-1] ^ flip;
         2'd1:    sr_sense = pipe[L] ^ flip;
         2'd2:    sr_sense = 1'b0 ^ flip;
         default: sr_sense = 1'b1 ^ flip;
      endcase
   end

   assign sat_sense = pipe2[D2-1];

   sr_chain_bist #(.LATENCY(L), .NBITS(N), .SEED(7'h7F)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sr_sense(sr_sense),
      .sr_drive(sr_drive), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err(first_err)
   );

   sr_chain_bist #(.LATENCY(L), .NBITS(N2), .SEED(7'h7F)) u_sat (
      .clk(clk), .rst(rst), .start(start2), .sr_sense(sat_sense),
      .sr_drive(sat_drive), .busy(sat_busy), .done(sat_done), .pass(sat_pass),
      .err_count(sat_err), .first_err(sat_first)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // returns half a cycle after the start edge
   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // counts busy cycles from now; optional extra start pulses at given offsets
   task automatic wait_busy(input int at1, input int at2, output int cycles);
      cycles = 0;
      while (busy && cycles < 2000) begin
         start = (cycles == at1 || cycles == at2);
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_drive", sr_drive, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_first", first_err, 16'hFFFF);

      // ideal loopback
      mode = 2'd0;
      pulse_start;
      check("launch_busy", busy, 1);
      check("launch_bit", sr_drive, 1);
      wait_busy(-1, -1, cyc);
      check("ideal_len", cyc, L + N);
      check("ideal_done", done, 1);
      check("ideal_pass", pass, 1);
      check("ideal_err", err_count, 0);
      check("ideal_first", first_err, 16'hFFFF);
      check("ideal_drive_idle", sr_drive, 0);

      // single inverted bit at check index 10
      pulse_start;
      repeat (L + 10) @(negedge clk);
      flip = 1'b1;
      @(negedge clk) flip = 1'b0;
      wait_busy(-1, -1, cyc);
      check("flip_err", err_count, 1);
      check("flip_first", first_err, 10);
      check("flip_pass", pass, 0);

      // stuck-at-0: ones in first 256 PRBS bits
      mode = 2'd2;
      pulse_start;
      wait_busy(-1, -1, cyc);
      check("s0_err", err_count, 130);
      check("s0_first", first_err, 0);
      check("s0_pass", pass, 0);

      // stuck-at-1: zeros; first zero of the seed-7F stream is bit 7
      mode = 2'd3;
      pulse_start;
      wait_busy(-1, -1, cyc);
      check("s1_err", err_count, 126);
      check("s1_first", first_err, 7);

      // restart from DONE clears results
      mode = 2'd0;
      pulse_start;
      check("redo_done", done, 0);
      check("redo_busy", busy, 1);
      check("redo_err", err_count, 0);
      check("redo_first", first_err, 16'hFFFF);
      wait_busy(-1, -1, cyc);
      check("redo_pass", pass, 1);

      // one extra cycle of loopback delay
      mode = 2'd1;
      pulse_start;
      wait_busy(-1, -1, cyc);
      check("late_err_ge100", err_count >= 8'd100, 1);
      check("late_pass", pass, 0);

      // start pulses in FILL and CHECK are ignored
      mode = 2'd0;
      pulse_start;
      wait_busy(20, 200, cyc);
      check("ign_len", cyc, L + N);
      check("ign_pass", pass, 1);

      // reset at check index 50 during a failing run
      mode = 2'd2;
      pulse_start;
      repeat (L + 50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_err", err_count, 0);
      check("mid_drive", sr_drive, 0);
      check("mid_first", first_err, 16'hFFFF);
      rst = 1'b0;
      mode = 2'd0;
      pulse_start;
      wait_busy(-1, -1, cyc);
      check("post_len", cyc, L + N);
      check("post_pass", pass, 1);

      // 1000-cycle loopback against a 128 latency: error count saturates
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      cyc = 0;
      while (sat_busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("sat_len", cyc, L + N2);
      check("sat_err", sat_err, 255);
      check("sat_first", sat_first, 0);
      check("sat_pass", sat_pass, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
